// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared FSM states and width default for the SPI shift engine
package spi_pkg;

    localparam int SPI_DWIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        XFER = 2'd2,
        DONE = 2'd3
    } spi_state_t;

endpackage

// File: rtl/spi_bit_counter.sv
// rtl/spi_bit_counter.sv - clearable bit counter with terminal-count flag
// Ports:
//   Sample_clk  clock, rising edge
//   rst         asynchronous active-low reset
//   i_clear     zero the count
//   i_inc       advance the count by one
//   o_last      count currently equals DWIDTH-1 (next increment completes a word)
module spi_bit_counter #(
    parameter int DWIDTH = 8
) (
    input  logic Sample_clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_inc,
    output logic o_last
);

    localparam int CW = $clog2(DWIDTH) + 1;

    logic [CW-1:0] r_count;

    always_ff @(posedge Sample_clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_inc) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_last = (r_count == CW'(DWIDTH - 1));

endmodule

// File: rtl/spi_shift_engine.sv
// rtl/spi_shift_engine.sv - SPI data shift engine with TX/RX buffers and status flags
// Ports:
//   Sample_clk, rst            clock and asynchronous active-low reset
//   sample_en, shift_en        SCK sample / shift edge strobes
//   start, dord                begin transfer, bit order (1 = LSB first)
//   Data_in, Data_out          serial in / registered serial out
//   SPDR_wr_en, SPDR_in        CPU write to TX buffer
//   SPDR_rd_en, SPDR_out       CPU read of RX buffer (read clears flags)
//   busy, spif, wcol, rx_ovr   status
module spi_shift_engine
    import spi_pkg::*;
#(
    parameter int DWIDTH = SPI_DWIDTH_DEFAULT
) (
    input  logic              rst,
    input  logic              Sample_clk,
    input  logic              sample_en,
    input  logic              shift_en,
    input  logic              start,
    input  logic              dord,
    input  logic              Data_in,
    output logic              Data_out,
    input  logic              SPDR_wr_en,
    input  logic [DWIDTH-1:0] SPDR_in,
    input  logic              SPDR_rd_en,
    output logic [DWIDTH-1:0] SPDR_out,
    output logic              busy,
    output logic              spif,
    output logic              wcol,
    output logic              rx_ovr
);

    spi_state_t        r_state;
    spi_state_t        w_next_state;
    logic [DWIDTH-1:0] r_tx_buf;
    logic [DWIDTH-1:0] r_rx_buf;
    logic [DWIDTH-1:0] r_shift_reg;
    logic              r_dord;
    logic              r_data_out;
    logic              r_spif;
    logic              r_wcol;
    logic              r_rx_ovr;

    logic              w_busy;
    logic              w_sample;
    logic              w_shift;
    logic              w_last;
    logic [DWIDTH-1:0] w_shifted;
    logic              w_out_cur;
    logic              w_out_post;

    assign w_busy   = (r_state != IDLE);
    assign w_sample = (r_state == XFER) && sample_en;
    assign w_shift  = (r_state == XFER) && shift_en;

    // Outgoing end is the MSB for MSB-first and the LSB for LSB-first;
    // received bits enter at the opposite end.
    assign w_shifted  = r_dord ? {Data_in, r_shift_reg[DWIDTH-1:1]}
                               : {r_shift_reg[DWIDTH-2:0], Data_in};
    assign w_out_cur  = r_dord ? r_shift_reg[0] : r_shift_reg[DWIDTH-1];
    assign w_out_post = r_dord ? w_shifted[0]   : w_shifted[DWIDTH-1];

    spi_bit_counter #(
        .DWIDTH (DWIDTH)
    ) u_bit_counter (
        .Sample_clk (Sample_clk),
        .rst        (rst),
        .i_clear    (r_state == LOAD),
        .i_inc      (w_sample),
        .o_last     (w_last)
    );

    always_ff @(posedge Sample_clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (start) w_next_state = LOAD;
            LOAD:    w_next_state = XFER;
            XFER:    if (w_sample && w_last) w_next_state = DONE;
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge Sample_clk or negedge rst) begin
        if (!rst) begin
            r_tx_buf    <= '0;
            r_rx_buf    <= '0;
            r_shift_reg <= '0;
            r_dord      <= 1'b0;
            r_data_out  <= 1'b0;
            r_spif      <= 1'b0;
            r_wcol      <= 1'b0;
            r_rx_ovr    <= 1'b0;
        end else begin
            if (r_state == IDLE && SPDR_wr_en) begin
                r_tx_buf <= SPDR_in;
            end

            if (r_state == LOAD) begin
                r_shift_reg <= r_tx_buf;
                r_dord      <= dord;
                r_data_out  <= dord ? r_tx_buf[0] : r_tx_buf[DWIDTH-1];
            end

            if (w_sample) begin
                r_shift_reg <= w_shifted;
            end

            // A coincident sample moves the word first, so the output must
            // present the bit that is outgoing after that move.
            if (w_shift) begin
                r_data_out <= w_sample ? w_out_post : w_out_cur;
            end

            if (r_state == DONE) begin
                r_rx_buf <= r_shift_reg;
            end

            // Setting a flag takes priority over a clearing read in the same cycle.
            if (r_state == DONE) begin
                r_spif <= 1'b1;
            end else if (SPDR_rd_en) begin
                r_spif <= 1'b0;
            end

            if (r_state == DONE && r_spif) begin
                r_rx_ovr <= 1'b1;
            end else if (SPDR_rd_en) begin
                r_rx_ovr <= 1'b0;
            end

            if (SPDR_wr_en && w_busy) begin
                r_wcol <= 1'b1;
            end else if (SPDR_rd_en) begin
                r_wcol <= 1'b0;
            end
        end
    end

    assign Data_out = r_data_out;
    assign SPDR_out = r_rx_buf;
    assign busy     = w_busy;
    assign spif     = r_spif;
    assign wcol     = r_wcol;
    assign rx_ovr   = r_rx_ovr;

endmodule

// File: tb/tb_spi_shift_engine.sv
// tb/tb_spi_shift_engine.sv - scoreboard bench for spi_shift_engine (DWIDTH = 8)
module tb_spi_shift_engine;

    logic       rst;
    logic       Sample_clk;
    logic       sample_en;
    logic       shift_en;
    logic       start;
    logic       dord;
    logic       Data_in;
    logic       Data_out;
    logic       SPDR_wr_en;
    logic [7:0] SPDR_in;
    logic       SPDR_rd_en;
    logic [7:0] SPDR_out;
    logic       busy;
    logic       spif;
    logic       wcol;
    logic       rx_ovr;

    spi_shift_engine #(.DWIDTH(8)) dut (
        .rst        (rst),
        .Sample_clk (Sample_clk),
        .sample_en  (sample_en),
        .shift_en   (shift_en),
        .start      (start),
        .dord       (dord),
        .Data_in    (Data_in),
        .Data_out   (Data_out),
        .SPDR_wr_en (SPDR_wr_en),
        .SPDR_in    (SPDR_in),
        .SPDR_rd_en (SPDR_rd_en),
        .SPDR_out   (SPDR_out),
        .busy       (busy),
        .spif       (spif),
        .wcol       (wcol),
        .rx_ovr     (rx_ovr)
    );

    initial Sample_clk = 1'b0;
    always #5 Sample_clk = ~Sample_clk;

    typedef struct packed {
        logic [7:0] word;
        logic       spif;
        logic       ovr;
        logic       wcol;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    logic m_spif = 1'b0;
    logic m_ovr  = 1'b0;
    logic m_wcol = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: a transfer is presented when busy drops outside reset.
    logic prev_busy = 1'b0;
    initial begin
        forever begin
            @(negedge Sample_clk);
            if (rst && prev_busy && !busy) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_completion", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("rx_word", {24'd0, SPDR_out}, {24'd0, e.word});
                    chk("spif", {31'd0, spif}, {31'd0, e.spif});
                    chk("rx_ovr", {31'd0, rx_ovr}, {31'd0, e.ovr});
                    chk("wcol", {31'd0, wcol}, {31'd0, e.wcol});
                end
            end
            prev_busy = busy;
        end
    end

    function automatic logic outbit(input logic [7:0] w, input logic d, input int k);
        return d ? w[k] : w[7-k];
    endfunction

    task automatic do_xfer(input logic wr, input logic [7:0] tx, input logic d,
                           input logic [7:0] rx, input logic loopb, input int col_at,
                           input logic both, input logic rd_done);
        exp_t e;
        e.word = loopb ? tx : rx;
        e.spif = 1'b1;
        e.ovr  = m_spif ? 1'b1 : (rd_done ? 1'b0 : m_ovr);
        e.wcol = rd_done ? 1'b0 : (m_wcol | (col_at >= 0));
        exp_q.push_back(e);

        SPDR_wr_en = wr; SPDR_in = tx; start = 1'b1; dord = d;
        @(negedge Sample_clk);
        SPDR_wr_en = 1'b0; start = 1'b0;
        @(negedge Sample_clk);
        chk("first_out", {31'd0, Data_out}, {31'd0, outbit(tx, d, 0)});
        for (int i = 0; i < 8; i++) begin
            Data_in   = loopb ? Data_out : outbit(rx, d, i);
            sample_en = 1'b1;
            shift_en  = both;
            if (i == col_at) begin
                SPDR_wr_en = 1'b1; SPDR_in = 8'hFF;
            end
            @(negedge Sample_clk);
            sample_en = 1'b0; shift_en = 1'b0; SPDR_wr_en = 1'b0;
            if (both) begin
                chk("both_out", {31'd0, Data_out},
                    {31'd0, (i < 7) ? outbit(tx, d, i + 1) : outbit(rx, d, 0)});
            end else if (i < 7) begin
                shift_en = 1'b1;
                @(negedge Sample_clk);
                shift_en = 1'b0;
                chk("shift_out", {31'd0, Data_out}, {31'd0, outbit(tx, d, i + 1)});
            end
        end
        chk("spif_in_done", {31'd0, spif}, {31'd0, m_spif});
        SPDR_rd_en = rd_done;
        @(negedge Sample_clk);
        SPDR_rd_en = 1'b0;
        m_spif = 1'b1; m_ovr = e.ovr; m_wcol = e.wcol;
        @(negedge Sample_clk);
    endtask

    task automatic do_read(input logic [7:0] word);
        SPDR_rd_en = 1'b1;
        @(negedge Sample_clk);
        SPDR_rd_en = 1'b0;
        chk("rd_spif", {31'd0, spif}, 32'd0);
        chk("rd_wcol", {31'd0, wcol}, 32'd0);
        chk("rd_ovr", {31'd0, rx_ovr}, 32'd0);
        chk("rd_word", {24'd0, SPDR_out}, {24'd0, word});
        m_spif = 1'b0; m_ovr = 1'b0; m_wcol = 1'b0;
    endtask

    initial begin
        rst = 1'b0; sample_en = 1'b0; shift_en = 1'b0; start = 1'b0; dord = 1'b0;
        Data_in = 1'b0; SPDR_wr_en = 1'b0; SPDR_in = 8'h00; SPDR_rd_en = 1'b0;
        repeat (3) @(negedge Sample_clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_spdr_out", {24'd0, SPDR_out}, 32'd0);
        chk("rst_spif", {31'd0, spif}, 32'd0);
        chk("rst_wcol", {31'd0, wcol}, 32'd0);
        chk("rst_ovr", {31'd0, rx_ovr}, 32'd0);
        chk("rst_dout", {31'd0, Data_out}, 32'd0);
        rst = 1'b1;
        @(negedge Sample_clk);

        do_xfer(1'b1, 8'hA5, 1'b0, 8'h3C, 1'b0, -1, 1'b0, 1'b0);
        do_read(8'h3C);
        do_xfer(1'b1, 8'h01, 1'b1, 8'h00, 1'b1, -1, 1'b0, 1'b0);
        do_read(8'h01);
        do_xfer(1'b1, 8'h5A, 1'b0, 8'hC3, 1'b0, 3, 1'b0, 1'b0);
        do_read(8'hC3);
        do_xfer(1'b0, 8'h5A, 1'b0, 8'h96, 1'b0, -1, 1'b0, 1'b0);
        do_xfer(1'b1, 8'h81, 1'b1, 8'h11, 1'b0, -1, 1'b0, 1'b0);
        do_read(8'h11);
        do_xfer(1'b1, 8'h7E, 1'b0, 8'hE7, 1'b0, -1, 1'b0, 1'b1);
        do_read(8'hE7);
        do_xfer(1'b1, 8'hC6, 1'b0, 8'h2B, 1'b0, -1, 1'b1, 1'b0);
        do_read(8'h2B);

        // Abort mid-transfer with reset.
        SPDR_wr_en = 1'b1; SPDR_in = 8'hF0; start = 1'b1; dord = 1'b0;
        @(negedge Sample_clk);
        SPDR_wr_en = 1'b0; start = 1'b0;
        @(negedge Sample_clk);
        for (int i = 0; i < 4; i++) begin
            Data_in = 1'b1; sample_en = 1'b1;
            @(negedge Sample_clk);
            sample_en = 1'b0;
        end
        #2 rst = 1'b0;
        #1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_spdr_out", {24'd0, SPDR_out}, 32'd0);
        chk("abort_spif", {31'd0, spif}, 32'd0);
        m_spif = 1'b0; m_ovr = 1'b0; m_wcol = 1'b0;
        @(negedge Sample_clk);
        start = 1'b1;
        @(negedge Sample_clk);
        chk("start_in_reset", {31'd0, busy}, 32'd0);
        start = 1'b0;
        rst = 1'b1;
        @(negedge Sample_clk);
        chk("post_rst_idle", {31'd0, busy}, 32'd0);
        do_xfer(1'b0, 8'h00, 1'b0, 8'h55, 1'b0, -1, 1'b0, 1'b0);

        for (int n = 0; n < 20 && exp_q.size() != 0; n++) @(negedge Sample_clk);
        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
